// File: rtl/upower_isa_pkg.sv
// upower_isa_pkg: shared uPower ISA definitions for the decode queue.
// Format tags, opcode / extended-opcode constants, field bit positions and
// the decoded-field bundle carried from the decoder into the output register.
package upower_isa_pkg;

    typedef enum logic [2:0] {
        FMT_X  = 3'd0,
        FMT_XO = 3'd1,
        FMT_D  = 3'd2,
        FMT_B  = 3'd3,
        FMT_I  = 3'd4,
        FMT_DS = 3'd5
    } fmt_t;

    // Primary opcodes
    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_ADDIS = 6'd15;
    localparam logic [5:0] OP_I     = 6'd18;
    localparam logic [5:0] OP_B     = 6'd19;
    localparam logic [5:0] OP_ORI   = 6'd24;
    localparam logic [5:0] OP_XORI  = 6'd26;
    localparam logic [5:0] OP_ANDI  = 6'd28;
    localparam logic [5:0] OP_31    = 6'd31;
    localparam logic [5:0] OP_LWZ   = 6'd32;
    localparam logic [5:0] OP_LBZ   = 6'd34;
    localparam logic [5:0] OP_STW   = 6'd36;
    localparam logic [5:0] OP_STWU  = 6'd37;
    localparam logic [5:0] OP_STB   = 6'd38;
    localparam logic [5:0] OP_LHZ   = 6'd40;
    localparam logic [5:0] OP_LHA   = 6'd42;
    localparam logic [5:0] OP_STH   = 6'd44;
    localparam logic [5:0] OP_LD    = 6'd58;
    localparam logic [5:0] OP_STD   = 6'd62;

    // 9-bit extended opcodes under primary 31 that select XO-form
    localparam logic [8:0] XO_ADD  = 9'd266;
    localparam logic [8:0] XO_SUBF = 9'd40;

    // Field LSB positions in the little-endian view of the 32-bit word
    localparam int OPCD_LSB = 26;
    localparam int RT_LSB   = 21;
    localparam int RA_LSB   = 16;
    localparam int RB_LSB   = 11;

    typedef struct packed {
        fmt_t       fmt;
        logic [5:0] opcode;
        logic [4:0] rt;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [9:0] xo;
        logic       oe;
        logic       rc;
        logic       aa;
        logic       lk;
        logic [1:0] dsxo;
        logic       illegal;
    } dec_fields_t;

    // D-form primary opcodes
    function automatic logic is_d_opcode(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIS, OP_ORI, OP_XORI, OP_ANDI, OP_LWZ, OP_LBZ,
            OP_STW, OP_STWU, OP_STB, OP_LHZ, OP_LHA, OP_STH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Every opcode this decoder understands
    function automatic logic is_known_opcode(input logic [5:0] op);
        return is_d_opcode(op) || (op == OP_I) || (op == OP_B) ||
               (op == OP_31) || (op == OP_LD) || (op == OP_STD);
    endfunction

endpackage

// File: rtl/upower_field_decode.sv
// upower_field_decode: purely combinational uPower field parser.
// Picks the instruction format, extracts the fields that format uses (all
// others forced to 0) and builds one sign-extended, pre-shifted immediate.
// Optional: UPOWER_ILLEGAL_CHECK_EN flags unlisted opcodes as illegal and
// zeroes their fields instead of decoding them as DS-form.
module upower_field_decode
    import upower_isa_pkg::*;
#(
    parameter int IMM_W = 64
) (
    input  logic [31:0]      instr,
    output dec_fields_t      fields,
    output logic [IMM_W-1:0] imm
);

    logic [5:0] opcode;
    logic [8:0] xo9;
    fmt_t       fmt;
    logic       illegal;

    assign opcode = instr[OPCD_LSB +: 6];
    assign xo9    = instr[9:1];

`ifdef UPOWER_ILLEGAL_CHECK_EN
    assign illegal = !is_known_opcode(opcode);
`else
    assign illegal = 1'b0;
`endif

    // Format selection from primary opcode (and XO9 under opcode 31)
    always_comb begin
        if (opcode == OP_31) begin
            fmt = (xo9 == XO_ADD || xo9 == XO_SUBF) ? FMT_XO : FMT_X;
        end else if (is_d_opcode(opcode)) begin
            fmt = FMT_D;
        end else if (opcode == OP_B) begin
            fmt = FMT_B;
        end else if (opcode == OP_I) begin
            fmt = FMT_I;
        end else begin
            fmt = FMT_DS;
        end
    end

    // Field extraction: only fields of the selected format are driven
    always_comb begin
        fields         = '0;
        imm            = '0;
        fields.fmt     = fmt;
        fields.opcode  = opcode;
        fields.illegal = illegal;
        case (fmt)
            FMT_X: begin
                fields.rt = instr[RT_LSB +: 5];
                fields.ra = instr[RA_LSB +: 5];
                fields.rb = instr[RB_LSB +: 5];
                fields.xo = instr[10:1];
                fields.rc = instr[0];
            end
            FMT_XO: begin
                fields.rt = instr[RT_LSB +: 5];
                fields.ra = instr[RA_LSB +: 5];
                fields.rb = instr[RB_LSB +: 5];
                fields.xo = {1'b0, xo9};
                fields.oe = instr[10];
                fields.rc = instr[0];
            end
            FMT_D: begin
                fields.rt = instr[RT_LSB +: 5];
                fields.ra = instr[RA_LSB +: 5];
                imm       = IMM_W'($signed(instr[15:0]));
            end
            FMT_B: begin
                fields.rt = instr[RT_LSB +: 5];
                fields.ra = instr[RA_LSB +: 5];
                fields.aa = instr[1];
                fields.lk = instr[0];
                imm       = IMM_W'($signed({instr[15:2], 2'b00}));
            end
            FMT_I: begin
                fields.aa = instr[1];
                fields.lk = instr[0];
                imm       = IMM_W'($signed({instr[25:2], 2'b00}));
            end
            FMT_DS: begin
                // Illegal opcodes land here too; they travel with fields cleared
                if (!illegal) begin
                    fields.rt   = instr[RT_LSB +: 5];
                    fields.ra   = instr[RA_LSB +: 5];
                    fields.dsxo = instr[1:0];
                    imm         = IMM_W'($signed({instr[15:2], 2'b00}));
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/upower_decode_queue.sv
// upower_decode_queue: DEPTH-entry raw-instruction FIFO feeding a registered
// decode output stage, valid/ready on both sides. Capacity is DEPTH + 1.
// in_ready depends only on the queue count so fetch never waits on the consumer
// combinationally. An empty pipeline bypasses the queue: an instruction
// accepted at edge N is presented right after edge N.
// Optional: UPOWER_ILLEGAL_CHECK_EN (handled inside upower_field_decode).
module upower_decode_queue
    import upower_isa_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IMM_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_fmt,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_ra,
    output logic [4:0]       out_rb,
    output logic [9:0]       out_xo,
    output logic             out_oe,
    output logic             out_rc,
    output logic             out_aa,
    output logic             out_lk,
    output logic [1:0]       out_dsxo,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    dec_fields_t      out_fields_reg;
    logic [IMM_W-1:0] out_imm_reg;
    logic             out_valid_reg;

    logic             q_empty, load_out, push_acc, bypass, q_push, q_pop;
    logic [31:0]      dec_src;
    dec_fields_t      dec_fields;
    logic [IMM_W-1:0] dec_imm;

    assign in_ready = (count_reg < CNT_W'(DEPTH));
    assign q_empty  = (count_reg == '0);
    assign load_out = !out_valid_reg || out_ready;
    assign push_acc = in_valid && in_ready && !flush;
    assign q_pop    = load_out && !q_empty;
    assign bypass   = load_out && q_empty && push_acc;
    assign q_push   = push_acc && !bypass;

    // Decode the queue head when anything is queued, otherwise the live input
    assign dec_src = q_empty ? in_instr : mem[rd_ptr_reg];

    upower_field_decode #(
        .IMM_W (IMM_W)
    ) u_decode (
        .instr  (dec_src),
        .fields (dec_fields),
        .imm    (dec_imm)
    );

    // Pointer wrap and occupancy update
    always_comb begin
        wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        case ({q_push, q_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Queue storage: data only, validity is tracked by the count
    always_ff @(posedge clk) begin
        if (q_push) begin
            mem[wr_ptr_reg] <= in_instr;
        end
    end

    // Queue pointers and count; flush empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (q_push) wr_ptr_reg <= wr_ptr_next;
            if (q_pop)  rd_ptr_reg <= rd_ptr_next;
            count_reg <= count_next;
        end
    end

    // Output register: reload when empty or being consumed, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_fields_reg <= '0;
            out_imm_reg    <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            out_fields_reg <= '0;
            out_imm_reg    <= '0;
        end else if (load_out) begin
            if (!q_empty || push_acc) begin
                out_valid_reg  <= 1'b1;
                out_fields_reg <= dec_fields;
                out_imm_reg    <= dec_imm;
            end else begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_fmt     = out_fields_reg.fmt;
    assign out_opcode  = out_fields_reg.opcode;
    assign out_rt      = out_fields_reg.rt;
    assign out_ra      = out_fields_reg.ra;
    assign out_rb      = out_fields_reg.rb;
    assign out_xo      = out_fields_reg.xo;
    assign out_oe      = out_fields_reg.oe;
    assign out_rc      = out_fields_reg.rc;
    assign out_aa      = out_fields_reg.aa;
    assign out_lk      = out_fields_reg.lk;
    assign out_dsxo    = out_fields_reg.dsxo;
    assign out_imm     = out_imm_reg;
    assign out_illegal = out_fields_reg.illegal;

endmodule
